// File: rtl/tx_pkg.sv
// Shared encodings and defaults for the TX frame scheduler.
// The header constant is only consumed when TX_FRAME_CTRL_HDR_EN is defined.
package tx_pkg;

    localparam int TX_DATA_WIDTH = 32;
    localparam int TX_LEN_WIDTH  = 16;

    localparam logic [15:0] TX_HDR_MAGIC = 16'hA5C3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_DATA = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } tx_state_e;

endpackage

// File: rtl/tx_frame_ctrl.sv
// Frame scheduler: slices the PRBS word stream into SOF/TLAST-delimited AXI-Stream frames.
// Define TX_FRAME_CTRL_HDR_EN to replace the first beat of every frame with a header word.
//
// state | meaning
// IDLE  | waiting for i_start
// LOAD  | capture run config, reseed PRBS, clear frame count
// DATA  | issuing beats of the current frame
// GAP   | idle cycles between frames
// DONE  | run finished, waiting for i_start to drop
module tx_frame_ctrl
    import tx_pkg::*;
#(
    parameter int C_DATA_WIDTH = TX_DATA_WIDTH,
    parameter int C_LEN_WIDTH  = TX_LEN_WIDTH
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_aresetn,
    input  logic                    i_start,
    input  logic [C_LEN_WIDTH-1:0]  i_frame_len,
    input  logic [C_LEN_WIDTH-1:0]  i_gap_len,
    input  logic [C_LEN_WIDTH-1:0]  i_num_frames,
    output logic                    o_prbs_load,
    output logic                    o_prbs_step,
    input  logic [C_DATA_WIDTH-1:0] i_prbs_data,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_sof,
    output logic                    m_axis_tlast,
    output logic [C_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [C_LEN_WIDTH-1:0]  o_frame_cnt
);

    localparam logic [C_LEN_WIDTH-1:0] ONE = C_LEN_WIDTH'(1);

    tx_state_e               state;
    logic [C_LEN_WIDTH-1:0]  len_q;
    logic [C_LEN_WIDTH-1:0]  gap_q;
    logic [C_LEN_WIDTH-1:0]  num_q;
    logic [C_LEN_WIDTH-1:0]  beats_left;
    logic [C_LEN_WIDTH-1:0]  gap_left;
    logic [C_LEN_WIDTH-1:0]  frame_cnt;
    logic                    first_q;
    logic                    stop_q;
    logic                    load_q;
    logic                    tvalid_q;
    logic                    sof_q;
    logic                    tlast_q;
    logic [C_DATA_WIDTH-1:0] tdata_q;

    logic                    issue;
    logic                    hs;
    logic                    frame_end;
    logic                    run_complete;
    logic [C_LEN_WIDTH-1:0]  len_eff;
    logic [C_LEN_WIDTH-1:0]  cnt_inc;
    logic [C_DATA_WIDTH-1:0] beat_data;

    assign hs           = tvalid_q && m_axis_tready;
    assign issue        = (state == ST_DATA) && (beats_left != '0) && (!tvalid_q || m_axis_tready);
    assign frame_end    = (state == ST_DATA) && hs && tlast_q;
    assign len_eff      = (i_frame_len == '0) ? ONE : i_frame_len;
    assign cnt_inc      = frame_cnt + ONE;
    assign run_complete = (num_q != '0) && (cnt_inc == num_q);

`ifdef TX_FRAME_CTRL_HDR_EN
    // The header beat carries the index of the frame it opens and consumes no PRBS word.
    assign beat_data   = first_q ? C_DATA_WIDTH'({TX_HDR_MAGIC, 16'(frame_cnt)}) : i_prbs_data;
    assign o_prbs_step = issue && !first_q;
`else
    assign beat_data   = i_prbs_data;
    assign o_prbs_step = issue;
`endif

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            state      <= ST_IDLE;
            len_q      <= '0;
            gap_q      <= '0;
            num_q      <= '0;
            beats_left <= '0;
            gap_left   <= '0;
            frame_cnt  <= '0;
            first_q    <= 1'b0;
            stop_q     <= 1'b0;
            load_q     <= 1'b0;
            tvalid_q   <= 1'b0;
            sof_q      <= 1'b0;
            tlast_q    <= 1'b0;
            tdata_q    <= '0;
        end else begin
            load_q <= 1'b0;

            if (issue) begin
                tdata_q    <= beat_data;
                tvalid_q   <= 1'b1;
                sof_q      <= first_q;
                tlast_q    <= (beats_left == ONE);
                beats_left <= beats_left - ONE;
                first_q    <= 1'b0;
            end else if (hs) begin
                tvalid_q <= 1'b0;
                sof_q    <= 1'b0;
                tlast_q  <= 1'b0;
            end

            unique case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        state  <= ST_LOAD;
                        load_q <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    len_q      <= len_eff;
                    gap_q      <= i_gap_len;
                    num_q      <= i_num_frames;
                    frame_cnt  <= '0;
                    beats_left <= len_eff;
                    first_q    <= 1'b1;
                    state      <= ST_DATA;
                end
                ST_DATA: begin
                    // i_start is only honoured here, at a frame boundary.
                    if (frame_end) begin
                        frame_cnt <= cnt_inc;
                        if (run_complete || !i_start) begin
                            state <= ST_DONE;
                        end else if (gap_q != '0) begin
                            state    <= ST_GAP;
                            gap_left <= gap_q;
                            stop_q   <= 1'b0;
                        end else begin
                            beats_left <= len_q;
                            first_q    <= 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (!i_start) begin
                        stop_q <= 1'b1;
                    end
                    if (gap_left == ONE) begin
                        if (stop_q || !i_start) begin
                            state <= ST_DONE;
                        end else begin
                            state      <= ST_DATA;
                            beats_left <= len_q;
                            first_q    <= 1'b1;
                        end
                    end else begin
                        gap_left <= gap_left - ONE;
                    end
                end
                ST_DONE: begin
                    if (!i_start) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_prbs_load   = load_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_sof    = sof_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tdata  = tdata_q;
    assign o_busy        = (state != ST_IDLE);
    assign o_done        = (state == ST_DONE);
    assign o_frame_cnt   = frame_cnt;

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// Directed bench for tx_frame_ctrl with a behavioural PRBS peer and a beat monitor.
// Header-mode vectors are included when TX_FRAME_CTRL_HDR_EN is defined.
module tb_tx_frame_ctrl;

    localparam int DW = 32;
    localparam int LW = 16;
`ifdef TX_FRAME_CTRL_HDR_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] flen = '0;
    logic [LW-1:0] glen = '0;
    logic [LW-1:0] nfr = '0;
    logic          tready = 1'b1;
    logic [DW-1:0] prbs_q = '0;
    logic [DW-1:0] seed = 32'h1ACE_B00C;
    logic          load, step, tvalid, sof, tlast, busy, done;
    logic [DW-1:0] tdata;
    logic [LW-1:0] fcnt;

    always #5 clk = ~clk;

    tx_frame_ctrl #(.C_DATA_WIDTH(DW), .C_LEN_WIDTH(LW)) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rstn),
        .i_start       (start),
        .i_frame_len   (flen),
        .i_gap_len     (glen),
        .i_num_frames  (nfr),
        .o_prbs_load   (load),
        .o_prbs_step   (step),
        .i_prbs_data   (prbs_q),
        .m_axis_tready (tready),
        .m_axis_tvalid (tvalid),
        .m_axis_sof    (sof),
        .m_axis_tlast  (tlast),
        .m_axis_tdata  (tdata),
        .o_busy        (busy),
        .o_done        (done),
        .o_frame_cnt   (fcnt)
    );

    function automatic logic [31:0] prbs_nxt(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    // External PRBS peer: reseed on load, advance on step.
    always @(posedge clk) begin
        if (load)      prbs_q <= seed;
        else if (step) prbs_q <= prbs_nxt(prbs_q);
    end

    int          cyc = 0, steps = 0, done_cyc = 0, stall_viol = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] pd;
    logic        ps, pl;
    logic [31:0] bq_data[$];
    logic        bq_sof[$];
    logic        bq_last[$];
    int          bq_cyc[$];

    always @(negedge clk) begin
        cyc++;
        if (prev_stall && (!tvalid || tdata !== pd || sof !== ps || tlast !== pl)) stall_viol++;
        prev_stall = rstn && tvalid && !tready;
        pd = tdata; ps = sof; pl = tlast;
        if (rstn && tvalid && tready) begin
            bq_data.push_back(tdata);
            bq_sof.push_back(sof);
            bq_last.push_back(tlast);
            bq_cyc.push_back(cyc);
        end
        if (step) steps++;
        if (done) done_cyc++;
    end

    int n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [31:0] exp_q[$];
    logic        exp_sof[$];
    logic        exp_last[$];
    int          exp_steps;

    task automatic build_exp(input int len, input int nframes);
        int          eff;
        logic [31:0] w;
        eff = (len == 0) ? 1 : len;
        w = seed;
        exp_q.delete(); exp_sof.delete(); exp_last.delete();
        exp_steps = 0;
        for (int f = 0; f < nframes; f++) begin
            for (int b = 0; b < eff; b++) begin
                if (HDR && b == 0) begin
                    exp_q.push_back({16'hA5C3, f[15:0]});
                end else begin
                    exp_q.push_back(w);
                    w = prbs_nxt(w);
                    exp_steps++;
                end
                exp_sof.push_back(b == 0);
                exp_last.push_back(b == eff - 1);
            end
        end
    endtask

    task automatic clear_mon();
        bq_data.delete(); bq_sof.delete(); bq_last.delete(); bq_cyc.delete();
        steps = 0; done_cyc = 0; stall_viol = 0;
    endtask

    task automatic check_beats(input string tag);
        int n;
        chk({tag, "_nbeats"}, bq_data.size(), exp_q.size());
        n = (bq_data.size() < exp_q.size()) ? bq_data.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_data%0d", tag, i), bq_data[i], exp_q[i]);
            chk($sformatf("%s_sof%0d", tag, i), bq_sof[i], exp_sof[i]);
            chk($sformatf("%s_last%0d", tag, i), bq_last[i], exp_last[i]);
        end
        chk({tag, "_steps"}, steps, exp_steps);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_done_reached"}, done, 1);
    endtask

    int st_cyc;

    initial begin
        // Reset state
        rstn = 1'b0;
        repeat (3) tick();
        chk("rst_tvalid", tvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fcnt", fcnt, 0);
        chk("rst_load", load, 0);
        chk("rst_tdata", tdata, 0);
        rstn = 1'b1;
        tick();

        // Frame shape: 3 frames of 4 beats, gap 2
        seed = 32'h1ACE_B00C;
        flen = 16'd4; glen = 16'd2; nfr = 16'd3; tready = 1'b1;
        clear_mon();
        build_exp(4, 3);
        start = 1'b1;
        st_cyc = cyc + 1;
        repeat (3) tick();
        flen = 16'd9;
        wait_done("shape", 200);
        check_beats("shape");
        chk("shape_fcnt", fcnt, 3);
        if (bq_cyc.size() >= 5) begin
            chk("shape_latency", bq_cyc[0] - st_cyc, 3);
            // one turnaround cycle after the tlast handshake plus the programmed gap
            chk("shape_idle", bq_cyc[4] - bq_cyc[3] - 1, 3);
        end
        repeat (3) tick();
        chk("shape_hold_done", done, 1);
        chk("shape_hold_nbeats", bq_data.size(), 12);
        start = 1'b0;
        tick();
        chk("shape_idle_done", done, 0);
        chk("shape_idle_busy", busy, 0);

        // Backpressure: tready toggles every cycle
        seed = 32'h0BAD_F00D;
        flen = 16'd8; glen = 16'd0; nfr = 16'd1; tready = 1'b1;
        clear_mon();
        build_exp(8, 1);
        start = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            tick();
            tready = ~tready;
        end
        tready = 1'b1;
        chk("bp_done_reached", done, 1);
        check_beats("bp");
        chk("bp_stall_hold", stall_viol, 0);
        start = 1'b0;
        tick();

        // Continuous run stopped mid-frame 3
        seed = 32'h7E57_C0DE;
        flen = 16'd5; glen = 16'd1; nfr = 16'd0;
        clear_mon();
        build_exp(5, 3);
        start = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            tick();
            if (bq_data.size() >= 12) start = 1'b0;
        end
        chk("stop_done_reached", done, 1);
        repeat (3) tick();
        check_beats("stop");
        chk("stop_fcnt", fcnt, 3);
        chk("stop_done_cycles", done_cyc, 1);
        chk("stop_busy", busy, 0);

        // Degenerate length: single-beat frames
        seed = 32'h0000_0001;
        flen = 16'd0; glen = 16'd0; nfr = 16'd4;
        clear_mon();
        build_exp(0, 4);
        start = 1'b1;
        wait_done("deg", 200);
        check_beats("deg");
        chk("deg_fcnt", fcnt, 4);
        start = 1'b0;
        tick();

        // Synchronous reset during a stall on beat 3
        seed = 32'hC0FF_EE11;
        flen = 16'd6; glen = 16'd0; nfr = 16'd1; tready = 1'b1;
        clear_mon();
        start = 1'b1;
        for (int i = 0; i < 100 && bq_data.size() < 2; i++) tick();
        tready = 1'b0;
        repeat (2) tick();
        chk("rst2_stalled", tvalid, 1);
        rstn = 1'b0;
        tick();
        chk("rst2_tvalid", tvalid, 0);
        chk("rst2_sof", sof, 0);
        chk("rst2_tlast", tlast, 0);
        chk("rst2_tdata", tdata, 0);
        chk("rst2_busy", busy, 0);
        chk("rst2_done", done, 0);
        chk("rst2_fcnt", fcnt, 0);
        chk("rst2_no_last", bq_last.size() > 0 ? bq_last[bq_last.size()-1] : 1'b0, 0);
        clear_mon();
        build_exp(6, 1);
        tready = 1'b1;
        rstn = 1'b1;
        wait_done("rerun", 200);
        check_beats("rerun");
        start = 1'b0;
        tick();

`ifdef TX_FRAME_CTRL_HDR_EN
        // Header mode: len 3, two frames
        seed = 32'h5EED_0042;
        flen = 16'd3; glen = 16'd0; nfr = 16'd2;
        clear_mon();
        build_exp(3, 2);
        start = 1'b1;
        wait_done("hdr", 200);
        check_beats("hdr");
        chk("hdr_steps4", steps, 4);
        start = 1'b0;
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
